codec_config_ctrl: RTL

CODEC_CONFIG_CTRL -- requirements
Module: codec_config_ctrl

---
 rtl/codec_config_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/codec_config_ctrl.sv
// Writes the fixed 11-entry codec register table over I2C after a start pulse, retrying NACKed frames.
// Bus timing comes from a quarter-bit tick that runs only while busy; every output is registered.
module codec_config_ctrl #(
    parameter int unsigned CLK_FREQ  = 25000000,
    parameter int unsigned I2C_FREQ  = 100000,
    parameter logic [6:0]  DEV_ADDR  = 7'h1A,
    parameter int unsigned MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       scl,
    output logic       sda_oe,
    input  logic       sda_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [3:0] err_index
);

    localparam int unsigned QDIV     = CLK_FREQ / (4 * I2C_FREQ);
    localparam int unsigned CW       = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam int unsigned RW       = $clog2(MAX_RETRY + 2);
    localparam logic [3:0]  LAST_IDX = 4'd10;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_SHIFT, S_ACK, S_STOP, S_GAP, S_DONE, S_FAIL
    } state_t;

    state_t          state_q, state_d;
    logic [1:0]      phase_q, phase_d;
    logic [2:0]      bit_q, bit_d;
    logic [1:0]      byte_q, byte_d;
    logic [3:0]      idx_q, idx_d;
    logic [RW-1:0]   retry_q, retry_d;
    logic            nack_q, nack_d;
    logic [CW-1:0]   cnt_q;
    logic            scl_q, scl_d;
    logic            sda_oe_q, sda_oe_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            error_q, error_d;
    logic [3:0]      err_index_q, err_index_d;
    logic            tick_w;
    logic [15:0]     ent_w;
    logic [7:0]      byte_w;

    // {reg[6:0], data[8:0]} per table index
    function automatic logic [15:0] tbl_entry(input logic [3:0] i);
        case (i)
            4'd0:    tbl_entry = {7'd15, 9'h000};
            4'd1:    tbl_entry = {7'd0,  9'h017};
            4'd2:    tbl_entry = {7'd1,  9'h017};
            4'd3:    tbl_entry = {7'd2,  9'h079};
            4'd4:    tbl_entry = {7'd3,  9'h079};
            4'd5:    tbl_entry = {7'd4,  9'h012};
            4'd6:    tbl_entry = {7'd5,  9'h000};
            4'd7:    tbl_entry = {7'd6,  9'h000};
            4'd8:    tbl_entry = {7'd7,  9'h002};
            4'd9:    tbl_entry = {7'd8,  9'h000};
            4'd10:   tbl_entry = {7'd9,  9'h001};
            default: tbl_entry = 16'h0000;
        endcase
    endfunction

    assign tick_w    = busy_q && (cnt_q == CW'(QDIV - 1));
    assign scl       = scl_q;
    assign sda_oe    = sda_oe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign error     = error_q;
    assign err_index = err_index_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            phase_q     <= '0;
            bit_q       <= '0;
            byte_q      <= '0;
            idx_q       <= '0;
            retry_q     <= '0;
            nack_q      <= 1'b0;
            cnt_q       <= '0;
            scl_q       <= 1'b1;
            sda_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            error_q     <= 1'b0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            bit_q       <= bit_d;
            byte_q      <= byte_d;
            idx_q       <= idx_d;
            retry_q     <= retry_d;
            nack_q      <= nack_d;
            cnt_q       <= (!busy_q || tick_w) ? '0 : cnt_q + CW'(1);
            scl_q       <= scl_d;
            sda_oe_q    <= sda_oe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            error_q     <= error_d;
            err_index_q <= err_index_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        bit_d       = bit_q;
        byte_d      = byte_q;
        idx_d       = idx_q;
        retry_d     = retry_q;
        nack_d      = nack_q;
        busy_d      = busy_q;
        done_d      = done_q;
        error_d     = error_q;
        err_index_d = err_index_q;
        ent_w       = '0;
        byte_w      = '0;
        scl_d       = 1'b1;
        sda_oe_d    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) begin
                    state_d     = S_START;
                    phase_d     = '0;
                    idx_d       = '0;
                    retry_d     = '0;
                    nack_d      = 1'b0;
                    busy_d      = 1'b1;
                    done_d      = 1'b0;
                    error_d     = 1'b0;
                    err_index_d = '0;
                end
            end
            default: begin
                if (tick_w) begin
                    phase_d = phase_q + 2'd1;
                    case (state_q)
                        S_START: begin
                            if (phase_q == 2'd3) begin
                                state_d = S_SHIFT;
                                bit_d   = '0;
                                byte_d  = '0;
                            end
                        end
                        S_SHIFT: begin
                            if (phase_q == 2'd3) begin
                                if (bit_q == 3'd7) state_d = S_ACK;
                                else               bit_d   = bit_q + 3'd1;
                            end
                        end
                        S_ACK: begin
                            // ACK is sampled on the tick that closes the high half of the bit
                            if (phase_q == 2'd2 && sda_in) begin
                                nack_d  = 1'b1;
                                retry_d = retry_q + RW'(1);
                            end
                            if (phase_q == 2'd3) begin
                                if (nack_q || byte_q == 2'd2) begin
                                    state_d = S_STOP;
                                end else begin
                                    state_d = S_SHIFT;
                                    byte_d  = byte_q + 2'd1;
                                    bit_d   = '0;
                                end
                            end
                        end
                        S_STOP: begin
                            if (phase_q == 2'd3) state_d = S_GAP;
                        end
                        S_GAP: begin
                            if (phase_q == 2'd3) begin
                                if (nack_q) begin
                                    nack_d = 1'b0;
                                    if (retry_q <= RW'(MAX_RETRY)) begin
                                        state_d = S_START;
                                    end else begin
                                        state_d     = S_FAIL;
                                        busy_d      = 1'b0;
                                        error_d     = 1'b1;
                                        err_index_d = idx_q;
                                    end
                                end else if (idx_q == LAST_IDX) begin
                                    state_d = S_DONE;
                                    busy_d  = 1'b0;
                                    done_d  = 1'b1;
                                end else begin
                                    state_d = S_START;
                                    idx_d   = idx_q + 4'd1;
                                    retry_d = '0;
                                end
                            end
                        end
                        default: ;
                    endcase
                end
            end
        endcase

        // Bus levels follow the next state so scl/sda_oe change on the same edge as the FSM
        ent_w = tbl_entry(idx_d);
        case (byte_d)
            2'd0:    byte_w = {DEV_ADDR, 1'b0};
            2'd1:    byte_w = ent_w[15:8];
            default: byte_w = ent_w[7:0];
        endcase
        case (state_d)
            S_START: begin
                scl_d    = (phase_d != 2'd3);
                sda_oe_d = (phase_d != 2'd0);
            end
            S_SHIFT: begin
                scl_d    = phase_d[0] ^ phase_d[1];
                sda_oe_d = ~byte_w[3'd7 - bit_d];
            end
            S_ACK: begin
                scl_d    = phase_d[0] ^ phase_d[1];
                sda_oe_d = 1'b0;
            end
            S_STOP: begin
                scl_d    = (phase_d != 2'd0);
                sda_oe_d = (phase_d != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
    end

endmodule
